// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I subset core.
// Walks one instruction at a time through fetch, decode and the execute,
// memory and writeback steps. It drives every enable and select the
// datapath needs for each step.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R,
    EXEC_I, ALUWB, BRANCH, JAL, JALR_ADR, JALR_PC, LUI
  } state_t;

  state_t state;

  logic       aluFunctOk;
  logic       rFunctOk;
  logic       branchFunctOk;
  logic       decodeIllegal;
  logic [2:0] aluFromFunct;

  // Shared funct3 -> ALU op map; funct7b5 only picks sub for register-register ops.
  always_comb begin
    aluFunctOk   = 1'b1;
    aluFromFunct = ALU_ADD;
    case (funct3)
      3'b000:  aluFromFunct = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  aluFromFunct = ALU_AND;
      3'b110:  aluFromFunct = ALU_OR;
      3'b100:  aluFromFunct = ALU_XOR;
      3'b010:  aluFromFunct = ALU_SLT;
      3'b011:  aluFromFunct = ALU_SLTU;
      default: aluFunctOk   = 1'b0;
    endcase
  end

  // Flag opcodes and function codes this core cannot execute, so DECODE can abandon them.
  always_comb begin
    rFunctOk      = aluFunctOk && ((funct3 == 3'b000) || !funct7b5);
    branchFunctOk = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
    case (op)
      OP_LW, OP_SW, OP_JAL, OP_JALR, OP_LUI: decodeIllegal = 1'b0;
      OP_R:    decodeIllegal = !rFunctOk;
      OP_I:    decodeIllegal = !aluFunctOk;
      OP_BR:   decodeIllegal = !branchFunctOk;
      default: decodeIllegal = 1'b1;
    endcase
  end

  // State sequencing; reset or any stray encoding lands back in FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    state <= DECODE;
        DECODE: begin
          if (decodeIllegal) begin
            state <= FETCH;
          end else begin
            case (op)
              OP_LW, OP_SW: state <= MEMADR;
              OP_R:         state <= EXEC_R;
              OP_I:         state <= EXEC_I;
              OP_BR:        state <= BRANCH;
              OP_JAL:       state <= JAL;
              OP_JALR:      state <= JALR_ADR;
              OP_LUI:       state <= LUI;
              default:      state <= FETCH;
            endcase
          end
        end
        MEMADR:   state <= (op == OP_SW) ? MEMWRITE : MEMREAD;
        MEMREAD:  state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: state <= FETCH;
        EXEC_R:   state <= ALUWB;
        EXEC_I:   state <= ALUWB;
        ALUWB:    state <= FETCH;
        BRANCH:   state <= FETCH;
        JAL:      state <= ALUWB;
        JALR_ADR: state <= JALR_PC;
        JALR_PC:  state <= ALUWB;
        LUI:      state <= FETCH;
        default:  state <= FETCH;
      endcase
    end
  end

  // Datapath controls per state; everything idles at 0 and is forced to 0 while in reset.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    ImmSrc     = 3'b000;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
        illegal = decodeIllegal;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_SW) ? IMM_S : IMM_I;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXEC_R: begin
        ALUSrcA    = 2'b10;
        ALUControl = aluFromFunct;
      end
      EXEC_I: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ImmSrc     = IMM_I;
        ALUControl = aluFromFunct;
      end
      ALUWB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA = 2'b10;
        case (funct3)
          3'b000: begin ALUControl = ALU_SUB; PCWrite = zero;  end
          3'b001: begin ALUControl = ALU_SUB; PCWrite = !zero; end
          3'b100: begin ALUControl = ALU_SLT; PCWrite = !zero; end
          3'b101: begin ALUControl = ALU_SLT; PCWrite = zero;  end
          default: ;
        endcase
      end
      JAL, JALR_PC: begin
        PCWrite = 1'b1;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      JALR_ADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = IMM_I;
      end
      LUI: begin
        ImmSrc    = IMM_U;
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;
      ImmSrc     = 3'b000;
      illegal    = 1'b0;
    end
  end

endmodule
